// File: rtl/scoreboard.sv
// ---------------------------------------------------------------------------
// scoreboard -- register-hazard interlock for the rv32 pipeline
//
// Purpose
//   Operand forwarding chooses where a source operand comes from. This block
//   chooses when decode may issue. It keeps, for each architectural register,
//   a count of writes in flight (wcnt) and of loads that have not yet left
//   the memory stage (lcnt). The combinational ready output holds decode back
//   on any hazard that forwarding cannot cover.
//
// Configuration macro
//   SCOREBOARD_FORWARD_EN
//     defined   : a forwarding network is present. Only load-use hazards stall,
//                 so a source hazards while lcnt != 0.
//     undefined : there is no forwarding. A source hazards while wcnt != 0.
//                 lcnt is still maintained but is not consulted.
//
// Parameters
//   DEPTH        maximum number of in-flight writes per register
//
// Ports
//   clk          clock
//   rst          synchronous reset, active-high; clears all tracking
//   flush        pipeline flush; clears all tracking at the next edge
//   id_valid     decode holds a valid instruction
//   id_ready     issue permitted; a transfer is id_valid && id_ready
//   id_rs1/2     source register addresses
//   id_rs1/2_used  the instruction reads that source
//   id_rd        destination register address
//   id_wr        the instruction writes rd
//   id_load      the instruction is a load
//   mm_done      a load leaves the memory stage this cycle (mm_rd)
//   wb_valid     writeback retires a register write this cycle (wb_rd)
//   pending      bit i = register i has at least one write in flight (registered)
//   busy         any pending bit is set (registered)
// ---------------------------------------------------------------------------
module scoreboard #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_wr,
  input  logic        id_load,
  input  logic        mm_done,
  input  logic [4:0]  mm_rd,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic [31:0] pending,
  output logic        busy
);

  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0]   C_ONE   = CW'(1);

  // -------------------------------------------------------------------------
  // Tracking state
  // -------------------------------------------------------------------------
  logic [CW-1:0] r_wcnt      [32];
  logic [CW-1:0] r_lcnt      [32];
  logic [CW-1:0] w_wcnt_next [32];
  logic [CW-1:0] w_lcnt_next [32];
  logic [31:0]   r_pending;
  logic          r_busy;
  logic [31:0]   w_pending_next;

  // -------------------------------------------------------------------------
  // Hazard detection (combinational from registered state only)
  // -------------------------------------------------------------------------
  logic [CW-1:0] w_rs1_track;
  logic [CW-1:0] w_rs2_track;
  logic          w_hazard1;
  logic          w_hazard2;
  logic          w_structural;
  logic          w_issue;

`ifdef SCOREBOARD_FORWARD_EN
  // Integer results are forwarded; only a load still ahead of the memory
  // stage can leave a consumer without data.
  assign w_rs1_track = r_lcnt[id_rs1];
  assign w_rs2_track = r_lcnt[id_rs2];
`else
  // No forwarding: any in-flight write must reach the register file first.
  assign w_rs1_track = r_wcnt[id_rs1];
  assign w_rs2_track = r_wcnt[id_rs2];
`endif

  assign w_hazard1    = id_rs1_used && (id_rs1 != 5'd0) && (w_rs1_track != '0);
  assign w_hazard2    = id_rs2_used && (id_rs2 != 5'd0) && (w_rs2_track != '0);
  // The counter for rd is full; one more write would overflow it.
  assign w_structural = id_wr && (r_wcnt[id_rd] == C_DEPTH);

  assign id_ready = !rst && !flush && !w_hazard1 && !w_hazard2 && !w_structural;

  // Because id_ready is low during flush/reset, no issue can leak through then.
  assign w_issue  = id_valid && id_ready && id_wr && (id_rd != 5'd0);

  // -------------------------------------------------------------------------
  // Counter next-state
  //   A simultaneous increment and decrement cancel. A decrement at zero is a
  //   protocol error and the counter holds at zero. The increment saturates
  //   at DEPTH, which matters only for lcnt under a malformed retire sequence.
  // -------------------------------------------------------------------------
  function automatic logic [CW-1:0] f_count_next(
    input logic [CW-1:0] cnt,
    input logic          inc,
    input logic          dec
  );
    logic [CW-1:0] res;
    res = cnt;
    if (inc && !dec && (cnt != C_DEPTH)) begin
      res = cnt + C_ONE;
    end else if (dec && !inc && (cnt != '0)) begin
      res = cnt - C_ONE;
    end
    return res;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0) begin : g_x0
        // x0 is hardwired to zero and never carries a hazard.
        assign w_wcnt_next[gi]    = '0;
        assign w_lcnt_next[gi]    = '0;
        assign w_pending_next[gi] = 1'b0;
      end else begin : g_xn
        logic w_inc_w;
        logic w_inc_l;
        logic w_dec_w;
        logic w_dec_l;

        assign w_inc_w = w_issue && (id_rd == 5'(gi));
        assign w_inc_l = w_inc_w && id_load;
        assign w_dec_w = wb_valid && (wb_rd == 5'(gi));
        assign w_dec_l = mm_done  && (mm_rd == 5'(gi));

        // A flush wipes all tracking, and retire events in that cycle are
        // dropped along with it.
        assign w_wcnt_next[gi] = flush ? '0 : f_count_next(r_wcnt[gi], w_inc_w, w_dec_w);
        assign w_lcnt_next[gi] = flush ? '0 : f_count_next(r_lcnt[gi], w_inc_l, w_dec_l);

        assign w_pending_next[gi] = (w_wcnt_next[gi] != '0);
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_wcnt[i] <= '0;
        r_lcnt[i] <= '0;
      end
      r_pending <= '0;
      r_busy    <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        r_wcnt[i] <= w_wcnt_next[i];
        r_lcnt[i] <= w_lcnt_next[i];
      end
      // These flags come from next-state, so they line up with the counters.
      r_pending <= w_pending_next;
      r_busy    <= |w_pending_next;
    end
  end

  assign pending = r_pending;
  assign busy    = r_busy;

endmodule
